// File: rtl/spi_bus_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one SPI flash/RAM engine.
// Optional macro SPI_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: data wins).
module spi_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        e_start,
    output logic        e_flash,
    output logic [23:0] e_addr,
    output logic        e_we,
    output logic [31:0] e_wdata,
    output logic [1:0]  e_size,
    input  logic        e_done,
    input  logic [31:0] e_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [1:0]  size;
    } req_t;

    state_t        state;
    logic [CW-1:0] tmo_cnt;
    logic          cur_d;
    req_t          win;
    logic          grant_d;
    logic          sel_flash;
    logic          sel_ram;
    logic          bad;
    logic          unused_addr_bits;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic last_d;
    assign grant_d = d_req & (~i_req | ~last_d);
`else
    assign grant_d = d_req;
`endif

    // Instruction fetches are always 4-byte reads.
    always_comb begin
        win = '0;
        if (grant_d) begin
            win.addr  = d_addr;
            win.we    = d_we;
            win.wdata = d_wdata;
            win.size  = d_size;
        end else begin
            win.addr  = i_addr;
            win.we    = 1'b0;
            win.wdata = '0;
            win.size  = 2'd2;
        end
    end

    assign sel_flash        = (win.addr[31:28] == 4'h8);
    assign sel_ram          = (win.addr[31:28] == 4'h0);
    assign bad              = ~(sel_flash | sel_ram) | (sel_flash & win.we);
    assign unused_addr_bits = ^win.addr[27:24];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            cur_d     <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            e_start   <= 1'b0;
            e_flash   <= 1'b0;
            e_addr    <= '0;
            e_we      <= 1'b0;
            e_wdata   <= '0;
            e_size    <= '0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            e_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        cur_d <= grant_d;
`ifdef SPI_ARB_ROUND_ROBIN_EN
                        last_d <= grant_d;
`endif
                        if (bad) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            i_ack     <= ~grant_d;
                            d_ack     <= grant_d;
                            state     <= RESP;
                        end else begin
                            e_start <= 1'b1;
                            e_flash <= sel_flash;
                            e_addr  <= win.addr[23:0];
                            e_we    <= win.we;
                            e_wdata <= win.wdata;
                            e_size  <= win.size;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // A completion in the final counted cycle beats the timeout.
                    if (e_done) begin
                        rsp_rdata <= e_rdata;
                        rsp_err   <= 1'b0;
                        i_ack     <= ~cur_d;
                        d_ack     <= cur_d;
                        state     <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        i_ack     <= ~cur_d;
                        d_ack     <= cur_d;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_ONE;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum number of cycles a transaction waits for e_done before it is aborted.
REQ-002 clk  input  1  the single clock; all logic is on the rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 i_req  input  1  instruction-fetch request, held until i_ack.
REQ-005 i_addr  input  32  instruction-fetch byte address; always a 4-byte read.
REQ-006 i_ack  output  1  one-cycle completion strobe for the instruction-fetch port.
REQ-007 d_req  input  1  data request, held until d_ack.
REQ-008 d_addr  input  32  data byte address.
REQ-009 d_we  input  1  data write (1) or read (0).
REQ-010 d_wdata  input  32  data write payload.
REQ-011 d_size  input  2  data access size: 0 = byte, 1 = half-word, 2 = word.
REQ-012 d_ack  output  1  one-cycle completion strobe for the data port.
REQ-013 rsp_rdata  output  32  read data, shared by both ports, valid in the ack cycle.
REQ-014 rsp_err  output  1  error flag, valid in the ack cycle.
REQ-015 e_start  output  1  one-cycle start strobe to the SPI engine.
REQ-016 e_flash  output  1  engine target select: 1 = flash chip select, 0 = RAM chip select.
REQ-017 e_addr  output  24  device address, equal to addr[23:0].
REQ-018 e_we  output  1  engine write enable.
REQ-019 e_wdata  output  32  engine write data.
REQ-020 e_size  output  2  engine access size.
REQ-021 e_done  input  1  one-cycle engine completion strobe.
REQ-022 e_rdata  input  32  engine read data, valid while e_done is high.

Function
REQ-023 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, and serve exactly one transaction at a time.
REQ-024 In IDLE with at least one request pending, the block SHALL select the winner and latch addr, we, wdata and size; instruction requests SHALL latch we=0 and size=2. Requester changes after the latch SHALL be ignored.
REQ-025 Address decode: addr[31:28]=4'h8 SHALL select flash; addr[31:28]=4'h0 SHALL select RAM; any other value is a decode error.
REQ-026 A write to flash is an error.
REQ-027 On any error, IDLE SHALL go directly to RESP without pulsing e_start.
REQ-028 On a legal request, IDLE SHALL go to ISSUE. ISSUE SHALL drive e_start high for exactly one cycle with the latched fields stable, then go to WAIT. The e_* fields SHALL hold their values until the next ISSUE.
REQ-029 In WAIT, e_done SHALL capture e_rdata into rsp_rdata, set rsp_err=0 and move to RESP.
REQ-030 In WAIT, the block SHALL count cycles. After TIMEOUT_CYCLES cycles without e_done it SHALL move to RESP with rsp_err=1 and rsp_rdata=0. If e_done arrives in the same cycle the timeout is reached, e_done SHALL win.
REQ-031 RESP SHALL assert the winner's ack for exactly one cycle, with rsp_rdata and rsp_err valid in that cycle, then return to IDLE.
REQ-032 rsp_rdata SHALL hold its value until the next response. On an error response rsp_rdata SHALL be 0.
REQ-033 Latency: with a request first seen in IDLE at cycle N, e_start SHALL be at N+1; with e_done at cycle M, ack SHALL be at M+1. A decode-error ack SHALL be at N+1.
REQ-034 A requester SHALL drop req in the cycle after its ack. A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-035 e_done outside WAIT SHALL be ignored.
REQ-036 Arbitration is evaluated only in IDLE. A request that arrives during a transaction SHALL wait and SHALL be evaluated in the next IDLE cycle.

Reset
REQ-037 While rst is high: state=IDLE, timeout counter=0, last-grant=instruction, and every output = 0 (i_ack, d_ack, rsp_rdata, rsp_err, e_start, e_flash, e_addr, e_we, e_wdata, e_size).
REQ-038 Reset during any state SHALL abort the transaction without an ack. e_start SHALL deassert immediately (asynchronously).

Configuration
REQ-039 With macro SPI_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port that was not granted last; the last-grant flag SHALL update at every grant. Single requests SHALL be granted as usual.
REQ-040 Without SPI_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to the data port (fixed priority), and no last-grant register SHALL exist.

Verification
REQ-041 Instruction read only: i_req with i_addr=0x80000100, e_done 5 cycles after e_start with e_rdata=0x00000013 -> e_flash=1, e_addr=0x000100, e_we=0, e_size=2; i_ack one cycle after e_done with rsp_rdata=0x00000013, rsp_err=0.
REQ-042 Data write: d_addr=0x00000040, d_we=1, d_wdata=0xDEADBEEF, d_size=0 -> e_flash=0, e_addr=0x000040, e_we=1, e_wdata=0xDEADBEEF, e_size=0; d_ack one cycle after e_done.
REQ-043 Errors: d_addr=0x40000000 -> d_ack one cycle later with rsp_err=1, rsp_rdata=0, no e_start; a data write to 0x80000000 -> same error response.
REQ-044 Simultaneous i_req and d_req held for two transactions -> order D,D without the macro and D,I with it; each ack is a single cycle.
REQ-045 Engine never asserts e_done, with TIMEOUT_CYCLES=16 -> ack 16 cycles after entering WAIT with rsp_err=1; reset asserted in WAIT -> no ack, all outputs 0.
